// File: rtl/slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE_WIDTH slice per clock, LSB slice first,
// carry rippled through a register; result and flags commit together on the last slice.
module slice_adder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SLICE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if ((DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_width
    $error("slice_adder: DATA_WIDTH must be a multiple of SLICE_WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  op_a, op_b, shadow, shadow_next;
  logic                   carry;
  logic [IDX_W-1:0]       idx;
  logic                   last;
  logic [31:0]            slice_base;
  logic [SLICE_WIDTH-1:0] slice_a, slice_b;
  logic [SLICE_WIDTH:0]   slice_sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Shadow including the slice being produced this cycle, so the commit edge
  // can publish the complete word without an extra cycle.
  always_comb begin
    last        = (idx == LAST_IDX);
    slice_base  = 32'(idx) * SLICE_WIDTH;
    slice_a     = op_a[slice_base +: SLICE_WIDTH];
    slice_b     = op_b[slice_base +: SLICE_WIDTH];
    slice_sum   = {1'b0, slice_a} + {1'b0, slice_b} + (SLICE_WIDTH+1)'(carry);
    shadow_next = shadow;
    shadow_next[slice_base +: SLICE_WIDTH] = slice_sum[SLICE_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      shadow    <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= A;
            op_b  <= sub ? ~B : B;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          shadow <= shadow_next;
          carry  <= slice_sum[SLICE_WIDTH];
          if (last) begin
            result    <= shadow_next;
            carry_out <= slice_sum[SLICE_WIDTH];
            overflow  <= (op_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                         (shadow_next[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
            done      <= 1'b1;
            idx       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_adder.sv
// Directed bench for slice_adder: 16/4 configuration for arithmetic, handshake,
// back-to-back and reset cases; 8/8 configuration for the single-slice case.
module tb_slice_adder;

  logic        clk;
  logic        rst, start, sub;
  logic [15:0] A, B;
  logic        busy, done, carry_out, overflow;
  logic [15:0] result;

  logic        rst8, start8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, carry_out8, overflow8;
  logic [7:0]  result8;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_res;

  slice_adder #(.DATA_WIDTH(16), .SLICE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );

  slice_adder #(.DATA_WIDTH(8), .SLICE_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result(result8),
    .carry_out(carry_out8), .overflow(overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er,
                        input logic ec, input logic ev);
    int unsigned n;
    start = 1'b1; sub = s; A = a; B = b;
    @(negedge clk);
    start = 1'b0; sub = ~s; A = 16'($urandom); B = 16'($urandom);
    n = 1;
    while (!done && n < 20) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_hold"}, result, last_res);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, ec);
    check({tag, "_ovf"}, overflow, ev);
    last_res = er;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst8_result", result8, 0);
    rst = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    run_op("add_ff_1",   1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    run_op("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("sub_5_7",    1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // Start held high: accepted at E0, E5 and E10; the E11 sample lands in RUN.
    start = 1'b1; sub = 1'b0; A = 16'h0003; B = 16'h0004;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin A = 16'h1111; B = 16'h2222; end
      check("b2b_done", done, (c == 5 || c == 10 || c == 15));
      check("b2b_busy", busy, !(c == 5 || c == 10 || c == 15 || c == 16));
      if (c == 5)  check("b2b_first", result, 16'h0007);
      if (c == 10) check("b2b_second", result, 16'h3333);
      if (c == 15) check("b2b_third", result, 16'h3333);
      if (c == 11) start = 1'b0;
    end
    last_res = 16'h3333;

    run_op("add_1234", 1'b0, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b0);

    // Abort mid-RUN: reset during the second RUN cycle.
    start = 1'b1; sub = 1'b0; A = 16'h0001; B = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy1", busy, 1);
    @(negedge clk);
    check("abort_busy2", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    check("abort_ovf", overflow, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    last_res = '0;
    run_op("after_abort", 1'b0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);

    // Single-slice configuration.
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    check("s1_busy", busy8, 1);
    check("s1_done_early", done8, 0);
    check("s1_hold", result8, 0);
    @(negedge clk);
    check("s1_done", done8, 1);
    check("s1_busy_at_done", busy8, 0);
    check("s1_result", result8, 8'h00);
    check("s1_carry", carry_out8, 1);
    check("s1_ovf", overflow8, 1);
    @(negedge clk);
    check("s1_done_pulse", done8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
